// File: rtl/switch_allocator_rr.sv
// rtl/switch_allocator_rr.sv - wormhole switch allocator with per-output round-robin arbitration
module switch_allocator_rr #(
  parameter int N     = 5,
  parameter int SEL_W = $clog2(N)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [0:N-1][0:N-1]     i_output_req,
  input  logic [0:N-1]            i_valid,
  input  logic [0:N-1]            i_tail,
  input  logic [0:N-1]            i_en,
  output logic [0:N-1][0:N-1]     o_grant,
  output logic [0:N-1][SEL_W-1:0] o_xbar_sel,
  output logic [0:N-1]            o_output_valid,
  output logic [0:N-1]            o_input_ack
);

  logic [0:N-1]            locked_q, locked_d;
  logic [0:N-1][SEL_W-1:0] owner_q, owner_d;
  logic [0:N-1][SEL_W-1:0] rr_ptr_q, rr_ptr_d;

  logic [0:N-1]            busy;
  logic [0:N-1]            xfer;
  logic [0:N-1][0:N-1]     first_req;
  logic [0:N-1][0:N-1]     qual_req;
  logic [0:N-1]            arb_found;
  logic [0:N-1][SEL_W-1:0] arb_win;
  logic [0:N-1]            claimed;

  // Candidate index base+k wrapped into 0..N-1; base < N and k <= N so one fold suffices.
  function automatic logic [SEL_W-1:0] wrap_add(input logic [SEL_W-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= N) s = s - N;
    return SEL_W'(s);
  endfunction

  // Per-output lock, owner and round-robin pointer; reset drops every lock immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      locked_q <= '0;
      owner_q  <= '0;
      rr_ptr_q <= {N{SEL_W'(N - 1)}};
    end else begin
      locked_q <= locked_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // An input is busy while it owns an output; xfer marks a flit crossing a locked output.
  always_comb begin
    busy = '0;
    xfer = '0;
    for (int j = 0; j < N; j++) begin
      if (locked_q[j]) begin
        busy[owner_q[j]] = 1'b1;
        xfer[j]          = i_valid[owner_q[j]] & i_en[j];
      end
    end
  end

  // Keep only the lowest requested output of each input, and only for valid, non-busy inputs.
  always_comb begin
    first_req = '0;
    qual_req  = '0;
    for (int i = 0; i < N; i++) begin
      for (int j = N - 1; j >= 0; j--) begin
        if (i_output_req[i][j]) begin
          first_req[i]    = '0;
          first_req[i][j] = 1'b1;
        end
      end
      if (i_valid[i] && !busy[i]) qual_req[i] = first_req[i];
    end
  end

  // Per output, the first qualified requester searching upward from rr_ptr+1.
  always_comb begin
    arb_found = '0;
    arb_win   = '0;
    for (int j = 0; j < N; j++) begin
      for (int k = 1; k <= N; k++) begin
        if (!arb_found[j] && qual_req[wrap_add(rr_ptr_q[j], k)][j]) begin
          arb_found[j] = 1'b1;
          arb_win[j]   = wrap_add(rr_ptr_q[j], k);
        end
      end
    end
  end

  // Next state: release on a tail transfer, lock idle outputs to their arbitration winners.
  always_comb begin
    locked_d = locked_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    claimed  = '0;
    for (int j = 0; j < N; j++) begin
      if (locked_q[j]) begin
        if (xfer[j] && i_tail[owner_q[j]]) begin
          locked_d[j] = 1'b0;
          rr_ptr_d[j] = owner_q[j];
        end
      end else if (arb_found[j] && !claimed[arb_win[j]]) begin
        // A doubly-won input stays with the lowest-index output; the others retry later.
        locked_d[j]         = 1'b1;
        owner_d[j]          = arb_win[j];
        claimed[arb_win[j]] = 1'b1;
      end
    end
  end

  // Decode lock state into the grant matrix, crossbar selects and transfer strobes.
  always_comb begin
    o_grant        = '0;
    o_xbar_sel     = '0;
    o_output_valid = '0;
    o_input_ack    = '0;
    for (int j = 0; j < N; j++) begin
      if (locked_q[j]) begin
        o_grant[owner_q[j]][j] = 1'b1;
        o_xbar_sel[j]          = owner_q[j];
        o_output_valid[j]      = xfer[j];
        if (xfer[j]) o_input_ack[owner_q[j]] = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_switch_allocator_rr.sv
// tb/tb_switch_allocator_rr.sv - directed and randomized checks of switch_allocator_rr against a behavioural model
module tb_switch_allocator_rr;
  localparam int N     = 5;
  localparam int SEL_W = $clog2(N);

  logic                    clk = 1'b0;
  logic                    reset_n;
  logic [0:N-1][0:N-1]     req;
  logic [0:N-1]            valid, tail, en;
  logic [0:N-1][0:N-1]     grant;
  logic [0:N-1][SEL_W-1:0] xbar_sel;
  logic [0:N-1]            output_valid, input_ack;

  int checks = 0;
  int errors = 0;

  // model state: owner per output (-1 = idle) and last owner pointer
  int m_owner[N];
  int m_ptr[N];
  logic [0:N-1][0:N-1]     exp_grant;
  logic [0:N-1][SEL_W-1:0] exp_sel;
  logic [0:N-1]            exp_ov, exp_ack;

  switch_allocator_rr #(.N(N), .SEL_W(SEL_W)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .i_output_req   (req),
    .i_valid        (valid),
    .i_tail         (tail),
    .i_en           (en),
    .o_grant        (grant),
    .o_xbar_sel     (xbar_sel),
    .o_output_valid (output_valid),
    .o_input_ack    (input_ack)
  );

  always #5 clk = ~clk;

  function automatic logic [0:N-1] oh(input int j);
    logic [0:N-1] v;
    v    = '0;
    v[j] = 1'b1;
    return v;
  endfunction

  function automatic int lowest_set(input logic [0:N-1] v);
    for (int j = 0; j < N; j++) if (v[j]) return j;
    return -1;
  endfunction

  function automatic void model_reset();
    for (int j = 0; j < N; j++) begin
      m_owner[j] = -1;
      m_ptr[j]   = N - 1;
    end
  endfunction

  function automatic void model_eval();
    exp_grant = '0;
    exp_sel   = '0;
    exp_ov    = '0;
    exp_ack   = '0;
    for (int j = 0; j < N; j++) begin
      if (m_owner[j] >= 0) begin
        exp_grant[m_owner[j]][j] = 1'b1;
        exp_sel[j] = SEL_W'(m_owner[j]);
        if (valid[m_owner[j]] && en[j]) begin
          exp_ov[j] = 1'b1;
          exp_ack[m_owner[j]] = 1'b1;
        end
      end
    end
  endfunction

  // closest requester after the pointer (cyclic distance) wins each idle output
  function automatic void model_advance();
    int nxt[N];
    bit busy_i[N];
    bit taken[N];
    int best, bestd, d;
    model_eval();
    for (int k = 0; k < N; k++) begin
      busy_i[k] = 1'b0;
      taken[k]  = 1'b0;
      nxt[k]    = m_owner[k];
    end
    for (int j = 0; j < N; j++) if (m_owner[j] >= 0) busy_i[m_owner[j]] = 1'b1;
    for (int j = 0; j < N; j++) begin
      if (m_owner[j] >= 0) begin
        if (exp_ov[j] && tail[m_owner[j]]) begin
          nxt[j]   = -1;
          m_ptr[j] = m_owner[j];
        end
      end else begin
        best  = -1;
        bestd = N + 1;
        for (int i = 0; i < N; i++) begin
          if (valid[i] && !busy_i[i] && lowest_set(req[i]) == j) begin
            d = (i - m_ptr[j] - 1 + 2 * N) % N;
            if (d < bestd) begin
              bestd = d;
              best  = i;
            end
          end
        end
        if (best >= 0 && !taken[best]) begin
          nxt[j]      = best;
          taken[best] = 1'b1;
        end
      end
    end
    for (int j = 0; j < N; j++) m_owner[j] = nxt[j];
  endfunction

  task automatic clear_inputs();
    req   = '0;
    valid = '0;
    tail  = '0;
    en    = '0;
  endtask

  task automatic tick();
    model_advance();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b1;
    clear_inputs();
    model_reset();
    #1;
    reset_n = 1'b0;
    #1;
    if (grant !== '0) begin $display("FAIL reset_grant got=%h exp=0", grant); errors++; end
    checks++;
    if (xbar_sel !== '0) begin $display("FAIL reset_sel got=%h exp=0", xbar_sel); errors++; end
    checks++;
    if (output_valid !== '0) begin $display("FAIL reset_ov got=%b exp=0", output_valid); errors++; end
    checks++;
    if (input_ack !== '0) begin $display("FAIL reset_ack got=%b exp=0", input_ack); errors++; end
    checks++;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(negedge clk);
    if (grant !== '0 || output_valid !== '0) begin
      $display("FAIL idle_after_reset grant=%h ov=%b exp=0", grant, output_valid); errors++;
    end
    checks++;
    tick();
  endtask

  task automatic test_single();
    logic [0:N-1][0:N-1] e;
    req[2] = oh(3); valid[2] = 1'b1; tail[2] = 1'b1; en[3] = 1'b1;
    @(negedge clk);
    if (grant !== '0 || output_valid !== '0) begin
      $display("FAIL single_arb_cycle grant=%h ov=%b exp=0", grant, output_valid); errors++;
    end
    checks++;
    tick();
    @(negedge clk);
    e = '0; e[2][3] = 1'b1;
    if (grant !== e) begin $display("FAIL single_grant got=%h exp=%h", grant, e); errors++; end
    checks++;
    if (output_valid !== oh(3) || input_ack !== oh(2)) begin
      $display("FAIL single_xfer ov=%b ack=%b exp ov=%b ack=%b", output_valid, input_ack, oh(3), oh(2)); errors++;
    end
    checks++;
    if (xbar_sel[3] !== 3'd2) begin $display("FAIL single_sel got=%0d exp=2", xbar_sel[3]); errors++; end
    checks++;
    tick();
    req[2] = '0; valid[2] = 1'b0; tail[2] = 1'b0;
    req[1] = oh(3); valid[1] = 1'b1; tail[1] = 1'b1;
    req[3] = oh(3); valid[3] = 1'b1; tail[3] = 1'b1;
    @(negedge clk);
    if (grant !== '0) begin $display("FAIL single_release got=%h exp=0", grant); errors++; end
    checks++;
    tick();
    @(negedge clk);
    e = '0; e[3][3] = 1'b1;
    if (grant !== e) begin $display("FAIL single_rotate got=%h exp=%h", grant, e); errors++; end
    checks++;
    tick();
    clear_inputs();
    tick();
  endtask

  task automatic test_round_robin();
    logic [0:N-1][0:N-1] e;
    int order[4];
    logic ev;
    order = '{0, 1, 4, 0};
    for (int i = 0; i < N; i++) begin
      if (i == 0 || i == 1 || i == 4) begin
        req[i] = oh(2); valid[i] = 1'b1; tail[i] = 1'b1;
      end
    end
    en[2] = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      ev = ((c % 2) == 1);
      e  = '0;
      if (ev) e[order[c / 2]][2] = 1'b1;
      if (grant !== e || output_valid[2] !== ev) begin
        $display("FAIL rr_order cyc=%0d grant=%h ov2=%b exp grant=%h ov2=%b", c, grant, output_valid[2], e, ev); errors++;
      end
      checks++;
      tick();
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_stall();
    logic [0:N-1][0:N-1] e;
    int acks;
    acks = 0;
    for (int c = 0; c < 10; c++) begin
      req[1] = oh(4); valid[1] = (c <= 7); tail[1] = (c == 7);
      req[2] = oh(4); valid[2] = 1'b1;     tail[2] = 1'b1;
      en[4]  = !(c >= 2 && c <= 4);
      @(negedge clk);
      e = '0;
      if (c >= 1 && c <= 7) e[1][4] = 1'b1;
      if (c == 9) e[2][4] = 1'b1;
      if (grant !== e) begin $display("FAIL stall_lock cyc=%0d got=%h exp=%h", c, grant, e); errors++; end
      checks++;
      if (input_ack[1]) acks++;
      tick();
    end
    if (acks != 4) begin $display("FAIL stall_acks got=%0d exp=4", acks); errors++; end
    checks++;
    clear_inputs();
    tick();
  endtask

  task automatic test_busy_ignore();
    logic [0:N-1][0:N-1] e;
    for (int c = 0; c < 6; c++) begin
      req[3]   = (c < 2) ? oh(1) : oh(2);
      valid[3] = 1'b1;
      tail[3]  = (c == 3 || c == 5);
      en[1]    = 1'b1;
      en[2]    = 1'b1;
      @(negedge clk);
      e = '0;
      if (c >= 1 && c <= 3) e[3][1] = 1'b1;
      if (c == 5) e[3][2] = 1'b1;
      if (grant !== e) begin $display("FAIL busy_ignore cyc=%0d got=%h exp=%h", c, grant, e); errors++; end
      checks++;
      tick();
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_reset_mid();
    logic [0:N-1][0:N-1] e;
    req[0] = oh(1); valid[0] = 1'b1; tail[0] = 1'b0; en[1] = 1'b1;
    @(negedge clk);
    tick();
    tick();
    @(negedge clk);
    e = '0; e[0][1] = 1'b1;
    if (grant !== e || input_ack !== oh(0)) begin
      $display("FAIL midpkt_lock grant=%h ack=%b exp grant=%h ack=%b", grant, input_ack, e, oh(0)); errors++;
    end
    checks++;
    #2;
    reset_n = 1'b0;
    #1;
    if (grant !== '0) begin $display("FAIL async_grant got=%h exp=0", grant); errors++; end
    checks++;
    if (output_valid !== '0 || input_ack !== '0) begin
      $display("FAIL async_xfer ov=%b ack=%b exp=0", output_valid, input_ack); errors++;
    end
    checks++;
    if (xbar_sel !== '0) begin $display("FAIL async_sel got=%h exp=0", xbar_sel); errors++; end
    checks++;
    clear_inputs();
    model_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    req[0] = oh(1); valid[0] = 1'b1; tail[0] = 1'b1;
    req[4] = oh(1); valid[4] = 1'b1; tail[4] = 1'b1;
    en[1]  = 1'b1;
    @(negedge clk);
    if (grant !== '0) begin $display("FAIL post_reset_arb got=%h exp=0", grant); errors++; end
    checks++;
    tick();
    @(negedge clk);
    e = '0; e[0][1] = 1'b1;
    if (grant !== e) begin $display("FAIL post_reset_winner got=%h exp=%h", grant, e); errors++; end
    checks++;
    tick();
    clear_inputs();
    tick();
  endtask

  task automatic test_non_onehot();
    logic [0:N-1][0:N-1] e;
    req[2][2] = 1'b1; req[2][3] = 1'b1; valid[2] = 1'b1; tail[2] = 1'b1; en = '1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      e = '0;
      if ((c % 2) == 1) e[2][2] = 1'b1;
      if (grant !== e || output_valid[3] !== 1'b0 || xbar_sel[3] !== '0) begin
        $display("FAIL non_onehot cyc=%0d grant=%h ov3=%b sel3=%0d exp grant=%h ov3=0 sel3=0",
                 c, grant, output_valid[3], xbar_sel[3], e); errors++;
      end
      checks++;
      tick();
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_random();
    bit bad;
    int cnt;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        valid[i] = ($urandom_range(0, 3) != 0);
        tail[i]  = ($urandom_range(0, 2) == 0);
        en[i]    = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 7) == 0) req[i] = N'($urandom());
        else req[i] = oh(int'($urandom_range(0, N - 1)));
      end
      @(negedge clk);
      model_eval();
      if (grant !== exp_grant) begin $display("FAIL rand_grant cyc=%0d got=%h exp=%h", c, grant, exp_grant); errors++; end
      checks++;
      if (xbar_sel !== exp_sel) begin $display("FAIL rand_sel cyc=%0d got=%h exp=%h", c, xbar_sel, exp_sel); errors++; end
      checks++;
      if (output_valid !== exp_ov) begin $display("FAIL rand_ov cyc=%0d got=%b exp=%b", c, output_valid, exp_ov); errors++; end
      checks++;
      if (input_ack !== exp_ack) begin $display("FAIL rand_ack cyc=%0d got=%b exp=%b", c, input_ack, exp_ack); errors++; end
      checks++;
      bad = 1'b0;
      for (int j = 0; j < N; j++) begin
        cnt = 0;
        for (int i = 0; i < N; i++) cnt += int'(grant[i][j]);
        if (cnt > 1) bad = 1'b1;
      end
      for (int i = 0; i < N; i++) if ($countones(grant[i]) > 1) bad = 1'b1;
      if (bad) begin $display("FAIL rand_onehot cyc=%0d grant=%h exp at most one per row and column", c, grant); errors++; end
      checks++;
      tick();
    end
    clear_inputs();
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_stall();
    test_busy_ignore();
    test_reset_mid();
    test_non_onehot();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
